sap_control_sequencer: RTL and testbench

- Microcoded control unit for the 8-bit bus computer. It sits directly upstream of the A/B/ALU block and drives its load_a, write_a, load_b, write_alu and enable_sub strobes.
- It also drives the PC, MAR, RAM, IR, flags and output-register controls.
- A step counter walks each instruction through fetch and execute micro-steps, decoding the IR opcode and the flags into one control word per cycle.

---
 rtl/sap_control_sequencer_if.sv | 41 ++++
 rtl/sap_control_sequencer.sv | 156 +++++++++++++++
 tb/tb_sap_control_sequencer.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/sap_control_sequencer_if.sv
// Sequencer-facing bundle: run/opcode/flag inputs and the control word driven onto the datapath.
// The master modport is the sequencer; the slave modport is the datapath consuming the strobes.
interface sap_control_sequencer_if #(
    parameter int OPCODE_W = 4
);
    logic                enable;
    logic [OPCODE_W-1:0] opcode;
    logic                carry_flag;
    logic                zero_flag;
    logic [2:0]          step;
    logic                halt;
    logic                pc_write;
    logic                pc_inc;
    logic                pc_load;
    logic                mar_load;
    logic                ram_write;
    logic                ram_load;
    logic                ir_load;
    logic                ir_write;
    logic                load_a;
    logic                write_a;
    logic                load_b;
    logic                write_alu;
    logic                enable_sub;
    logic                flags_load;
    logic                out_load;

    modport master (
        input  enable, opcode, carry_flag, zero_flag,
        output step, halt, pc_write, pc_inc, pc_load, mar_load, ram_write, ram_load,
               ir_load, ir_write, load_a, write_a, load_b, write_alu, enable_sub,
               flags_load, out_load
    );

    modport slave (
        output enable, opcode, carry_flag, zero_flag,
        input  step, halt, pc_write, pc_inc, pc_load, mar_load, ram_write, ram_load,
               ir_load, ir_write, load_a, write_a, load_b, write_alu, enable_sub,
               flags_load, out_load
    );
endinterface

// File: rtl/sap_control_sequencer.sv
// Microcoded step sequencer: control word is a zero-latency decode of registered step/opcode/flags.
// enable=0 pauses the step counter with the current word held; HLT freezes everything until clear_n.
module sap_control_sequencer #(
    parameter int OPCODE_W  = 4,
    parameter int STEPS     = 5,
    parameter bit EARLY_END = 1'b1
) (
    input  logic                  clk,
    input  logic                  clear_n,
    sap_control_sequencer_if.master bus
);
    typedef struct packed {
        logic pc_write;
        logic pc_inc;
        logic pc_load;
        logic mar_load;
        logic ram_write;
        logic ram_load;
        logic ir_load;
        logic ir_write;
        logic load_a;
        logic write_a;
        logic load_b;
        logic write_alu;
        logic enable_sub;
        logic flags_load;
        logic out_load;
    } ctrl_t;

    localparam logic [2:0] T0 = 3'd0;
    localparam logic [2:0] T1 = 3'd1;
    localparam logic [2:0] T2 = 3'd2;
    localparam logic [2:0] T3 = 3'd3;
    localparam logic [2:0] T4 = 3'd4;
    localparam logic [2:0] LAST_STEP = 3'(STEPS - 1);

    localparam logic [OPCODE_W-1:0] OP_LDA = OPCODE_W'(4'b0001);
    localparam logic [OPCODE_W-1:0] OP_ADD = OPCODE_W'(4'b0010);
    localparam logic [OPCODE_W-1:0] OP_SUB = OPCODE_W'(4'b0011);
    localparam logic [OPCODE_W-1:0] OP_STA = OPCODE_W'(4'b0100);
    localparam logic [OPCODE_W-1:0] OP_LDI = OPCODE_W'(4'b0101);
    localparam logic [OPCODE_W-1:0] OP_JMP = OPCODE_W'(4'b0110);
    localparam logic [OPCODE_W-1:0] OP_JC  = OPCODE_W'(4'b0111);
    localparam logic [OPCODE_W-1:0] OP_JZ  = OPCODE_W'(4'b1000);
    localparam logic [OPCODE_W-1:0] OP_OUT = OPCODE_W'(4'b1110);
    localparam logic [OPCODE_W-1:0] OP_HLT = OPCODE_W'(4'b1111);

    logic [2:0] r_step;
    logic       r_halt;
    ctrl_t      w_ctrl;
    ctrl_t      w_ctrl_out;
    logic [2:0] w_last;
    logic       w_hlt_now;
    logic       w_wrap;

    always_comb begin
        w_ctrl = '0;
        case (r_step)
            T0: begin
                w_ctrl.pc_write = 1'b1;
                w_ctrl.mar_load = 1'b1;
            end
            T1: begin
                w_ctrl.ram_write = 1'b1;
                w_ctrl.ir_load   = 1'b1;
                w_ctrl.pc_inc    = 1'b1;
            end
            default: begin
                case (bus.opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        if (r_step == T2) begin
                            w_ctrl.ir_write = 1'b1;
                            w_ctrl.mar_load = 1'b1;
                        end else if (r_step == T3) begin
                            w_ctrl.ram_write = (bus.opcode != OP_STA);
                            w_ctrl.load_a    = (bus.opcode == OP_LDA);
                            w_ctrl.load_b    = (bus.opcode == OP_ADD) || (bus.opcode == OP_SUB);
                            w_ctrl.write_a   = (bus.opcode == OP_STA);
                            w_ctrl.ram_load  = (bus.opcode == OP_STA);
                        end else if (r_step == T4 && (bus.opcode == OP_ADD || bus.opcode == OP_SUB)) begin
                            w_ctrl.write_alu  = 1'b1;
                            w_ctrl.load_a     = 1'b1;
                            w_ctrl.flags_load = 1'b1;
                            w_ctrl.enable_sub = (bus.opcode == OP_SUB);
                        end
                    end
                    OP_LDI, OP_JMP, OP_JC, OP_JZ: begin
                        if (r_step == T2) begin
                            w_ctrl.ir_write = 1'b1;
                            w_ctrl.load_a   = (bus.opcode == OP_LDI);
                            w_ctrl.pc_load  = (bus.opcode == OP_JMP)
                                           || (bus.opcode == OP_JC && bus.carry_flag)
                                           || (bus.opcode == OP_JZ && bus.zero_flag);
                        end
                    end
                    OP_OUT: begin
                        if (r_step == T2) begin
                            w_ctrl.write_a  = 1'b1;
                            w_ctrl.out_load = 1'b1;
                        end
                    end
                    default: w_ctrl = '0;
                endcase
            end
        endcase
    end

    // Untaken conditional jumps still finish at T2; unused opcodes behave as NOP.
    always_comb begin
        case (bus.opcode)
            OP_LDA, OP_STA: w_last = T3;
            OP_ADD, OP_SUB: w_last = T4;
            OP_LDI, OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: w_last = T2;
            default:        w_last = T1;
        endcase
    end

    assign w_hlt_now = (r_step == T2) && (bus.opcode == OP_HLT);
    assign w_wrap    = (r_step == LAST_STEP) || (EARLY_END && (r_step == w_last));

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            r_step <= T0;
            r_halt <= 1'b0;
        end else if (bus.enable && !r_halt) begin
            if (w_hlt_now) begin
                r_halt <= 1'b1;
            end else if (w_wrap) begin
                r_step <= T0;
            end else begin
                r_step <= r_step + 3'd1;
            end
        end
    end

    // Gating by clear_n makes reset kill the word asynchronously, not just at the next edge.
    assign w_ctrl_out = (clear_n && !r_halt) ? w_ctrl : '0;

    assign bus.step       = r_step;
    assign bus.halt       = r_halt;
    assign bus.pc_write   = w_ctrl_out.pc_write;
    assign bus.pc_inc     = w_ctrl_out.pc_inc;
    assign bus.pc_load    = w_ctrl_out.pc_load;
    assign bus.mar_load   = w_ctrl_out.mar_load;
    assign bus.ram_write  = w_ctrl_out.ram_write;
    assign bus.ram_load   = w_ctrl_out.ram_load;
    assign bus.ir_load    = w_ctrl_out.ir_load;
    assign bus.ir_write   = w_ctrl_out.ir_write;
    assign bus.load_a     = w_ctrl_out.load_a;
    assign bus.write_a    = w_ctrl_out.write_a;
    assign bus.load_b     = w_ctrl_out.load_b;
    assign bus.write_alu  = w_ctrl_out.write_alu;
    assign bus.enable_sub = w_ctrl_out.enable_sub;
    assign bus.flags_load = w_ctrl_out.flags_load;
    assign bus.out_load   = w_ctrl_out.out_load;
endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for the control sequencer: one EARLY_END=1 instance and one EARLY_END=0 instance.
module tb_sap_control_sequencer;
    localparam logic [14:0] CO = 15'h4000;
    localparam logic [14:0] CE = 15'h2000;
    localparam logic [14:0] J  = 15'h1000;
    localparam logic [14:0] MI = 15'h0800;
    localparam logic [14:0] RO = 15'h0400;
    localparam logic [14:0] RI = 15'h0200;
    localparam logic [14:0] II = 15'h0100;
    localparam logic [14:0] IO = 15'h0080;
    localparam logic [14:0] AI = 15'h0040;
    localparam logic [14:0] AO = 15'h0020;
    localparam logic [14:0] BI = 15'h0010;
    localparam logic [14:0] EO = 15'h0008;
    localparam logic [14:0] SU = 15'h0004;
    localparam logic [14:0] FI = 15'h0002;
    localparam logic [14:0] OI = 15'h0001;
    localparam logic [14:0] NONE = 15'h0000;

    logic clk;
    logic clear_n0;
    logic clear_n1;
    int   n_checks;
    int   n_errors;

    sap_control_sequencer_if if0 ();
    sap_control_sequencer_if if1 ();

    sap_control_sequencer #(.EARLY_END(1'b1)) dut0 (.clk(clk), .clear_n(clear_n0), .bus(if0.master));
    sap_control_sequencer #(.EARLY_END(1'b0)) dut1 (.clk(clk), .clear_n(clear_n1), .bus(if1.master));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [14:0] cw(input int which);
        if (which == 0)
            return {if0.pc_write, if0.pc_inc, if0.pc_load, if0.mar_load, if0.ram_write, if0.ram_load,
                    if0.ir_load, if0.ir_write, if0.load_a, if0.write_a, if0.load_b, if0.write_alu,
                    if0.enable_sub, if0.flags_load, if0.out_load};
        return {if1.pc_write, if1.pc_inc, if1.pc_load, if1.mar_load, if1.ram_write, if1.ram_load,
                if1.ir_load, if1.ir_write, if1.load_a, if1.write_a, if1.load_b, if1.write_alu,
                if1.enable_sub, if1.flags_load, if1.out_load};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic exp_state(input string tag, input int which, input logic [2:0] step,
                             input logic [14:0] word, input logic halt);
        check({tag, "_step"}, (which == 0) ? 32'(if0.step) : 32'(if1.step), 32'(step));
        check({tag, "_cw"},   32'(cw(which)), 32'(word));
        check({tag, "_halt"}, (which == 0) ? 32'(if0.halt) : 32'(if1.halt), 32'(halt));
    endtask

    // Every cycle: advance one edge, sample 1ns later, and confirm a single bus driver per DUT.
    task automatic tick();
        @(posedge clk);
        #1;
        check("excl0", 32'($countones({if0.pc_write, if0.ram_write, if0.ir_write, if0.write_a, if0.write_alu}) <= 1), 32'd1);
        check("excl1", 32'($countones({if1.pc_write, if1.ram_write, if1.ir_write, if1.write_a, if1.write_alu}) <= 1), 32'd1);
    endtask

    task automatic run_instr(input string tag, input logic [3:0] op, input int last,
                             input logic [14:0] t2, input logic [14:0] t3, input logic [14:0] t4);
        if0.opcode = op;
        exp_state({tag, "_t0"}, 0, 3'd0, CO | MI, 1'b0);
        tick();
        exp_state({tag, "_t1"}, 0, 3'd1, RO | II | CE, 1'b0);
        if (last >= 2) begin
            tick();
            exp_state({tag, "_t2"}, 0, 3'd2, t2, 1'b0);
        end
        if (last >= 3) begin
            tick();
            exp_state({tag, "_t3"}, 0, 3'd3, t3, 1'b0);
        end
        if (last >= 4) begin
            tick();
            exp_state({tag, "_t4"}, 0, 3'd4, t4, 1'b0);
        end
        tick();
        exp_state({tag, "_end"}, 0, 3'd0, CO | MI, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        clear_n0 = 1'b0;
        clear_n1 = 1'b0;
        if0.enable = 1'b1;  if0.opcode = 4'b0010;  if0.carry_flag = 1'b0;  if0.zero_flag = 1'b0;
        if1.enable = 1'b1;  if1.opcode = 4'b0101;  if1.carry_flag = 1'b0;  if1.zero_flag = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        exp_state("reset0", 0, 3'd0, NONE, 1'b0);
        exp_state("reset1", 1, 3'd0, NONE, 1'b0);

        clear_n0 = 1'b1;
        #1;
        run_instr("add", 4'b0010, 4, IO | MI, RO | BI, EO | AI | FI);
        run_instr("sub", 4'b0011, 4, IO | MI, RO | BI, EO | AI | FI | SU);
        run_instr("lda", 4'b0001, 3, IO | MI, RO | AI, NONE);
        run_instr("sta", 4'b0100, 3, IO | MI, AO | RI, NONE);
        run_instr("ldi", 4'b0101, 2, IO | AI, NONE, NONE);
        run_instr("jmp", 4'b0110, 2, IO | J, NONE, NONE);
        if0.zero_flag = 1'b0;  if0.carry_flag = 1'b1;
        run_instr("jz_nt", 4'b1000, 2, IO, NONE, NONE);
        if0.zero_flag = 1'b1;  if0.carry_flag = 1'b0;
        run_instr("jz_t", 4'b1000, 2, IO | J, NONE, NONE);
        run_instr("jc_nt", 4'b0111, 2, IO, NONE, NONE);
        if0.carry_flag = 1'b1;
        run_instr("jc_t", 4'b0111, 2, IO | J, NONE, NONE);
        run_instr("out", 4'b1110, 2, AO | OI, NONE, NONE);
        run_instr("nop", 4'b0000, 1, NONE, NONE, NONE);
        run_instr("op1010", 4'b1010, 1, NONE, NONE, NONE);

        // SUB paused at T3, then reset mid-instruction.
        if0.opcode = 4'b0011;
        tick();
        tick();
        tick();
        exp_state("pause_t3", 0, 3'd3, RO | BI, 1'b0);
        if0.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_state("pause_hold", 0, 3'd3, RO | BI, 1'b0);
        end
        clear_n0 = 1'b0;
        #1;
        exp_state("pause_clr", 0, 3'd0, NONE, 1'b0);
        #1;
        if0.enable = 1'b1;
        clear_n0 = 1'b1;
        #1;
        exp_state("pause_rel", 0, 3'd0, CO | MI, 1'b0);

        // HLT freezes at T2 until an asynchronous clear.
        if0.opcode = 4'b1111;
        tick();
        exp_state("hlt_t1", 0, 3'd1, RO | II | CE, 1'b0);
        tick();
        exp_state("hlt_t2", 0, 3'd2, NONE, 1'b0);
        for (int i = 0; i < 20; i++) begin
            tick();
            exp_state("hlt_hold", 0, 3'd2, NONE, 1'b1);
        end
        #3;
        clear_n0 = 1'b0;
        #1;
        exp_state("hlt_clr", 0, 3'd0, NONE, 1'b0);
        if0.opcode = 4'b0000;
        #1;
        clear_n0 = 1'b1;
        #1;
        exp_state("hlt_rel_t0", 0, 3'd0, CO | MI, 1'b0);
        tick();
        exp_state("hlt_rel_t1", 0, 3'd1, RO | II | CE, 1'b0);
        tick();
        exp_state("hlt_rel_nop", 0, 3'd0, CO | MI, 1'b0);

        // Random opcode/flag/enable stream; HLT excluded so the stream keeps moving.
        for (int i = 0; i < 1000; i++) begin
            if0.opcode     = 4'($urandom_range(0, 14));
            if0.carry_flag = 1'($urandom_range(0, 1));
            if0.zero_flag  = 1'($urandom_range(0, 1));
            if0.enable     = ($urandom_range(0, 3) != 0);
            tick();
            check("rand_step_range", 32'(if0.step < 3'd5), 32'd1);
            check("rand_no_halt", 32'(if0.halt), 32'd0);
        end

        // EARLY_END=0: LDI runs all five steps with empty T3/T4.
        #1;
        clear_n1 = 1'b1;
        #1;
        exp_state("full_t0", 1, 3'd0, CO | MI, 1'b0);
        tick();
        exp_state("full_t1", 1, 3'd1, RO | II | CE, 1'b0);
        tick();
        exp_state("full_t2", 1, 3'd2, IO | AI, 1'b0);
        tick();
        exp_state("full_t3", 1, 3'd3, NONE, 1'b0);
        tick();
        exp_state("full_t4", 1, 3'd4, NONE, 1'b0);
        tick();
        exp_state("full_end", 1, 3'd0, CO | MI, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
